// File: rtl/conv_kernel_nxn.sv
// KxK signed convolution kernel: column-fed sliding window, horizontal stride, runtime weights,
// bias, arithmetic rescale, optional ReLU and output saturation. Four-stage pipeline, 1 window/cycle.
module conv_kernel_nxn #(
    parameter int unsigned K      = 5,
    parameter int unsigned DW     = 16,
    parameter int unsigned BW     = 32,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned SHIFT  = 0,
    parameter int unsigned STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  row_start_i,
    input  logic                  in_valid_i,
    input  logic [K*DW-1:0]       d_in_i,
    input  logic                  w_load_i,
    input  logic [K*K*DW-1:0]     w_in_i,
    input  logic [BW-1:0]         b_in_i,
    input  logic                  relu_en_i,
    output logic [OUT_W-1:0]      d_out_o,
    output logic                  out_valid_o
);

    localparam int unsigned ACC_W = 2 * DW + $clog2(K * K) + 1;
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned NT    = K * K;
    localparam int unsigned XW    = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;
    localparam int unsigned CW    = $clog2(K + 1);
    localparam int unsigned SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0]        KCnt       = CW'(K);
    localparam logic [SW-1:0]        StrideLast = SW'(STRIDE - 1);
    localparam logic signed [XW-1:0] OutMax     = {{(XW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [XW-1:0] OutMin     = {{(XW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [DW-1:0]    win_q  [K][K];
    logic signed [DW-1:0]    w_q    [NT];
    logic signed [BW-1:0]    b_q;
    logic signed [PW-1:0]    prod_q [NT];
    logic signed [ACC_W-1:0] sum_d, sum_q;
    logic signed [XW-1:0]    biased, shifted;
    logic [OUT_W-1:0]        res_d, d_out_q;
    logic [CW-1:0]           col_cnt_d, col_cnt_q;
    logic [SW-1:0]           stride_cnt_d, stride_cnt_q;
    logic                    emit_d, emit_q, v1_q, v2_q, out_valid_q;

    // Fill tracking and stride decimation for the column being accepted this cycle.
    always_comb begin
        col_cnt_d    = col_cnt_q;
        stride_cnt_d = stride_cnt_q;
        emit_d       = 1'b0;
        if (in_valid_i) begin
            if (row_start_i) begin
                col_cnt_d    = CW'(1);
                stride_cnt_d = '0;
            end else if (col_cnt_q != KCnt) begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
            if (col_cnt_d == KCnt) begin
                emit_d       = (stride_cnt_d == '0);
                stride_cnt_d = (stride_cnt_d == StrideLast) ? '0 : stride_cnt_d + 1'b1;
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NT; i++) begin
            sum_d = sum_d + ACC_W'(prod_q[i]);
        end
    end

    // Extra headroom bit keeps sum + bias exact before rescale and clamp.
    always_comb begin
        biased  = XW'(sum_q) + XW'(b_q);
        shifted = biased >>> SHIFT;
        if (relu_en_i && shifted < 0) begin
            shifted = '0;
        end
        if (shifted > OutMax) begin
            res_d = OutMax[OUT_W-1:0];
        end else if (shifted < OutMin) begin
            res_d = OutMin[OUT_W-1:0];
        end else begin
            res_d = shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            for (int i = 0; i < NT; i++) begin
                w_q[i]    <= '0;
                prod_q[i] <= '0;
            end
            b_q          <= '0;
            sum_q        <= '0;
            col_cnt_q    <= '0;
            stride_cnt_q <= '0;
            emit_q       <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            d_out_q      <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            stride_cnt_q <= stride_cnt_d;
            emit_q       <= emit_d;
            if (in_valid_i) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                    win_q[r][K-1] <= d_in_i[r*DW +: DW];
                end
            end
            if (w_load_i) begin
                for (int i = 0; i < NT; i++) begin
                    w_q[i] <= w_in_i[i*DW +: DW];
                end
                b_q <= b_in_i;
            end
            v1_q <= emit_q;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod_q[r*K+c] <= PW'(win_q[r][c]) * PW'(w_q[r*K+c]);
                end
            end
            v2_q        <= v1_q;
            sum_q       <= sum_d;
            out_valid_q <= v2_q;
            if (v2_q) begin
                d_out_q <= res_d;
            end
        end
    end

    assign d_out_o     = d_out_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_conv_kernel_nxn.sv
// Scoreboard bench for conv_kernel_nxn: three instances (default, STRIDE=2, OUT_W=8) share
// stimulus, each gated by its own in_valid, and each has a monitor popping an expectation queue.
module tb_conv_kernel_nxn;

    localparam int K  = 5;
    localparam int DW = 16;
    localparam int BW = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             row_start = 1'b0;
    logic             in_valid = 1'b0;
    logic             w_load = 1'b0;
    logic             relu_en = 1'b0;
    logic [K*DW-1:0]  d_in = '0;
    logic [K*K*DW-1:0] w_in = '0;
    logic [BW-1:0]    b_in = '0;
    int               sel = 0;

    logic        iv_a, iv_s, iv_n;
    logic [31:0] d_out_a, d_out_s;
    logic [7:0]  d_out_n;
    logic        ov_a, ov_s, ov_n;

    assign iv_a = in_valid && (sel == 0);
    assign iv_s = in_valid && (sel == 1);
    assign iv_n = in_valid && (sel == 2);

    conv_kernel_nxn u_a (
        .clk(clk), .rst_n(rst_n), .row_start_i(row_start), .in_valid_i(iv_a), .d_in_i(d_in),
        .w_load_i(w_load), .w_in_i(w_in), .b_in_i(b_in), .relu_en_i(relu_en),
        .d_out_o(d_out_a), .out_valid_o(ov_a)
    );

    conv_kernel_nxn #(.STRIDE(2)) u_s (
        .clk(clk), .rst_n(rst_n), .row_start_i(row_start), .in_valid_i(iv_s), .d_in_i(d_in),
        .w_load_i(w_load), .w_in_i(w_in), .b_in_i(b_in), .relu_en_i(relu_en),
        .d_out_o(d_out_s), .out_valid_o(ov_s)
    );

    conv_kernel_nxn #(.OUT_W(8)) u_n (
        .clk(clk), .rst_n(rst_n), .row_start_i(row_start), .in_valid_i(iv_n), .d_in_i(d_in),
        .w_load_i(w_load), .w_in_i(w_in), .b_in_i(b_in), .relu_en_i(relu_en),
        .d_out_o(d_out_n), .out_valid_o(ov_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_s[$];
    exp_t q_n[$];
    exp_t e_a, e_s, e_n;
    int vectors = 0;
    int errors  = 0;

    always @(negedge clk) begin
        if (ov_a) begin
            vectors++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_strobe: unexpected out_valid at cycle %0d, d_out=%0d, required none",
                         cyc, $signed(d_out_a));
            end else begin
                e_a = q_a.pop_front();
                if (d_out_a !== e_a.val || cyc != e_a.cyc) begin
                    errors++;
                    $display("FAIL a_result: got %0d at cycle %0d, required %0d at cycle %0d",
                             $signed(d_out_a), cyc, $signed(e_a.val), e_a.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ov_s) begin
            vectors++;
            if (q_s.size() == 0) begin
                errors++;
                $display("FAIL s_strobe: unexpected out_valid at cycle %0d, d_out=%0d, required none",
                         cyc, $signed(d_out_s));
            end else begin
                e_s = q_s.pop_front();
                if (d_out_s !== e_s.val || cyc != e_s.cyc) begin
                    errors++;
                    $display("FAIL s_result: got %0d at cycle %0d, required %0d at cycle %0d",
                             $signed(d_out_s), cyc, $signed(e_s.val), e_s.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ov_n) begin
            vectors++;
            if (q_n.size() == 0) begin
                errors++;
                $display("FAIL n_strobe: unexpected out_valid at cycle %0d, d_out=%0d, required none",
                         cyc, $signed(d_out_n));
            end else begin
                e_n = q_n.pop_front();
                if (d_out_n !== e_n.val[7:0] || cyc != e_n.cyc) begin
                    errors++;
                    $display("FAIL n_result: got %0d at cycle %0d, required %0d at cycle %0d",
                             $signed(d_out_n), cyc, $signed(e_n.val[7:0]), e_n.cyc);
                end
            end
        end
    end

    // Result is due on the 4th edge counting the one that accepts the column.
    task automatic push_exp(input int v);
        exp_t e;
        e.val = 32'(v);
        e.cyc = cyc + 4;
        case (sel)
            0:       q_a.push_back(e);
            1:       q_s.push_back(e);
            default: q_n.push_back(e);
        endcase
    endtask

    task automatic drive_col(input int pix, input bit rs, input bit expect_out, input int val);
        for (int r = 0; r < K; r++) d_in[r*DW +: DW] = DW'(pix);
        row_start = rs;
        in_valid  = 1'b1;
        if (expect_out) push_exp(val);
        @(negedge clk);
        in_valid  = 1'b0;
        row_start = 1'b0;
    endtask

    task automatic set_weights(input int w, input int b);
        for (int i = 0; i < K * K; i++) w_in[i*DW +: DW] = DW'(w);
        b_in   = BW'(b);
        w_load = 1'b1;
        @(negedge clk);
        w_load = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q_a.size() + q_s.size() + q_n.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if ((q_a.size() + q_s.size() + q_n.size()) != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected strobes never arrived, required 0", name,
                     q_a.size() + q_s.size() + q_n.size());
            q_a.delete();
            q_s.delete();
            q_n.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 3;
        if ({ov_a, ov_s, ov_n} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid: out_valid a/s/n=%b, required 000", {ov_a, ov_s, ov_n});
        end
        if (d_out_a !== 32'd0 || d_out_s !== 32'd0) begin
            errors++;
            $display("FAIL reset_dout: d_out a=%0d s=%0d, required 0", d_out_a, d_out_s);
        end
        if (d_out_n !== 8'd0) begin
            errors++;
            $display("FAIL reset_dout_n: d_out=%0d, required 0", d_out_n);
        end
        rst_n = 1'b1;
        @(negedge clk);
        // No w_load since reset: weights and bias are zero, so a full window yields 0.
        for (int c = 0; c < 5; c++) drive_col(7, c == 0, c == 4, 0);
        drain("reset_weights");
    endtask

    task automatic test_basic();
        set_weights(1, 1);
        for (int c = 0; c < 7; c++) drive_col(2, c == 0, c >= 4, 51);
        drain("basic");
        vectors++;
        if (d_out_a !== 32'd51 || ov_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: d_out=%0d valid=%b, required 51 and 0", d_out_a, ov_a);
        end
    endtask

    task automatic test_gaps();
        for (int c = 1; c <= 6; c++) begin
            drive_col(c, c == 1, c >= 5, 5 * (5 * c - 10) + 1);
            @(negedge clk);
        end
        drain("gaps");
    endtask

    task automatic test_stride();
        sel = 1;
        set_weights(1, 0);
        for (int c = 1; c <= 9; c++) drive_col(1, c == 1, c == 5 || c == 7 || c == 9, 25);
        drain("stride");
        sel = 0;
    endtask

    task automatic test_relu_sat();
        set_weights(-1, 0);
        relu_en = 1'b1;
        for (int c = 0; c < 5; c++) drive_col(100, c == 0, c == 4, 0);
        drain("relu_on");
        relu_en = 1'b0;
        for (int c = 0; c < 5; c++) drive_col(100, c == 0, c == 4, -2500);
        drain("relu_off");
        sel = 2;
        set_weights(127, 0);
        for (int c = 0; c < 5; c++) drive_col(127, c == 0, c == 4, 127);
        drain("sat_pos");
        set_weights(-128, 0);
        for (int c = 0; c < 5; c++) drive_col(127, c == 0, c == 4, -128);
        drain("sat_neg");
        sel = 0;
    endtask

    task automatic test_row_restart();
        set_weights(1, 0);
        for (int c = 0; c < 3; c++) drive_col(9, c == 0, 1'b0, 0);
        for (int c = 0; c < 5; c++) drive_col(1, c == 0, c == 4, 25);
        drain("row_restart");
    endtask

    task automatic test_reset_flight();
        for (int c = 0; c < 6; c++) drive_col(3, c == 0, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ov_a !== 1'b0 || d_out_a !== 32'd0) begin
            errors++;
            $display("FAIL flight_reset: valid=%b d_out=%0d, required 0 and 0", ov_a, d_out_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (ov_a !== 1'b0) begin
            errors++;
            $display("FAIL flight_stale: out_valid=%b after release, required 0", ov_a);
        end
    endtask

    task automatic test_wload_midflight();
        set_weights(1, 0);
        for (int c = 0; c < 5; c++) drive_col(1, c == 0, c == 4, 25);
        for (int i = 0; i < K * K; i++) w_in[i*DW +: DW] = DW'(2);
        b_in   = '0;
        w_load = 1'b1;
        drive_col(1, 1'b0, 1'b1, 50);
        w_load = 1'b0;
        drain("wload");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_gaps();
        test_stride();
        test_relu_sat();
        test_row_restart();
        test_reset_flight();
        test_wload_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
